// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame constants.
package uart_pkg;

   localparam int D_W_DEF    = 8;
   localparam int B_TICK_DEF = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_DATA  = ST_DATA,
      S_STOP  = ST_STOP,
      S_BREAK = ST_BREAK
   } state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous level input, with a selectable reset value.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: validates the start bit at half a bit, samples data at
// mid-bit, checks the stop bit and writes good bytes to the RX FIFO as a one-cycle strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int D_W    = D_W_DEF,
   parameter int B_TICK = B_TICK_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           b_en,
   input  logic           rx,
   input  logic           fifo_full,
   output logic [D_W-1:0] rx_data,
   output logic           rx_valid,
   output logic           frame_err,
   output logic           overrun_err,
   output logic           busy,
   output state_e         fsm_state
);

   localparam int TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
   localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;
   localparam logic [TW-1:0] HALF_LAST = TW'(B_TICK / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);

   logic rx_s;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rx_s)
   );

   state_e         state_q, state_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [D_W-1:0] shreg_q, shreg_d;
   logic [D_W-1:0] data_q, data_d;
   logic           valid_q, valid_d;
   logic           ferr_q, ferr_d;
   logic           ovr_q, ovr_d;
   logic           busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               tick_d  = '0;
            end
         end
         S_START: begin
            if (b_en) begin
               if (tick_q == HALF_LAST) begin
                  // Line back high at mid start bit: treat as a glitch.
                  state_d = rx_s ? S_IDLE : S_DATA;
                  tick_d  = '0;
                  bit_d   = '0;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (b_en) begin
               if (tick_q == TICK_LAST) begin
                  shreg_d = {rx_s, shreg_q[D_W-1:1]};
                  tick_d  = '0;
                  if (bit_q == BIT_LAST) state_d = S_STOP;
                  else                   bit_d   = bit_q + BW'(1);
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (b_en) begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (!rx_s) begin
                     ferr_d  = 1'b1;
                     state_d = S_BREAK;
                  end else if (fifo_full) begin
                     ovr_d   = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign frame_err   = ferr_q;
   assign overrun_err = ovr_q;
   assign busy        = busy_q;
   assign fsm_state   = state_q;

endmodule
